// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pipe_stall_ctrl_pkg;

  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } stall_state_t;

  // Per-stage controls, MSB first in the order they are driven out.
  typedef struct packed {
    logic pcWriteEn;
    logic ifidWriteEn;
    logic idexWriteEn;
    logic exmemWriteEn;
    logic ifidFlush;
    logic idexBubble;
    logic memwbBubble;
  } stage_ctrl_t;

  // Everything held, nothing injected (reset / illegal state).
  localparam stage_ctrl_t CTRL_OFF    = 7'b0000000;
  // Whole pipe frozen; MEM/WB gets a bubble so the stalled access never retires twice.
  localparam stage_ctrl_t CTRL_FROZEN = 7'b0000001;

  // Controls when memory is not holding the pipe. A taken branch squashes the
  // ID instruction, so a load-use hazard against it is moot.
  function automatic stage_ctrl_t run_ctrl(input logic branchTaken, input logic luHaz);
    stage_ctrl_t c;
    c = 7'b1111000;
    if (branchTaken) begin
      c.ifidFlush  = 1'b1;
      c.idexBubble = 1'b1;
    end else if (luHaz) begin
      c.pcWriteEn   = 1'b0;
      c.ifidWriteEn = 1'b0;
      c.idexBubble  = 1'b1;
    end
    return c;
  endfunction

endpackage

// File: rtl/pipe_stall_ctrl_hazard_detect.sv
// Load-use hazard compare between the EX load and the ID consumer.
// Latency: purely combinational.
// Backpressure: none; result feeds the stall sequencer.
// Ports: idRs/idRt/idUsesRt describe the ID instruction; exMemRead/exRegWriteEn/
//        exWBAddress describe the EX instruction; luHaz is the hazard flag.
import pipe_stall_ctrl_pkg::*;

module pipe_stall_ctrl_hazard_detect (
  input  logic [REG_ADDR_W-1:0] idRs,
  input  logic [REG_ADDR_W-1:0] idRt,
  input  logic                  idUsesRt,
  input  logic                  exMemRead,
  input  logic                  exRegWriteEn,
  input  logic [REG_ADDR_W-1:0] exWBAddress,
  output logic                  luHaz
);

  logic rsMatch;
  logic rtMatch;

  assign rsMatch = (exWBAddress == idRs);
  assign rtMatch = idUsesRt & (exWBAddress == idRt);

  // Register 0 is hardwired, so a load targeting it never creates a dependency.
  assign luHaz = exMemRead & exRegWriteEn & (exWBAddress != REG_ZERO) & (rsMatch | rtMatch);

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, taken branch, memory wait states.
// Latency: stage controls are combinational from state and inputs; state/counters update next edge.
// Backpressure: memReq without memReady freezes every stage; a wait longer than MEM_TIMEOUT latches ERROR.
// Ports: clock/reset; ID/EX hazard fields; exBranchTaken; memReq/memReady;
//        four register write-enables, ifidFlush/idexBubble/memwbBubble,
//        sticky memTimeoutErr and saturating stallCount (cycles with pcWriteEn=0).
import pipe_stall_ctrl_pkg::*;

module pipe_stall_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 4,
  parameter int STALL_CNT_W = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [REG_ADDR_W-1:0]  idRs,
  input  logic [REG_ADDR_W-1:0]  idRt,
  input  logic                   idUsesRt,
  input  logic                   exMemRead,
  input  logic                   exRegWriteEn,
  input  logic [REG_ADDR_W-1:0]  exWBAddress,
  input  logic                   exBranchTaken,
  input  logic                   memReq,
  input  logic                   memReady,
  output logic                   pcWriteEn,
  output logic                   ifidWriteEn,
  output logic                   idexWriteEn,
  output logic                   exmemWriteEn,
  output logic                   ifidFlush,
  output logic                   idexBubble,
  output logic                   memwbBubble,
  output logic                   memTimeoutErr,
  output logic [STALL_CNT_W-1:0] stallCount
);

  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  stall_state_t     state, stateNxt;
  logic [CNT_W-1:0] waitCnt, waitCntNxt;
  logic             errSet;
  logic             luHaz;
  logic             memStall;
  stage_ctrl_t      ctrl;

  pipe_stall_ctrl_hazard_detect u_hazard (
    .idRs         (idRs),
    .idRt         (idRt),
    .idUsesRt     (idUsesRt),
    .exMemRead    (exMemRead),
    .exRegWriteEn (exRegWriteEn),
    .exWBAddress  (exWBAddress),
    .luHaz        (luHaz)
  );

  assign memStall = memReq & ~memReady;

  always_comb begin
    ctrl       = CTRL_OFF;
    stateNxt   = state;
    waitCntNxt = waitCnt;
    errSet     = 1'b0;
    case (state)
      RUN: begin
        if (memStall) begin
          ctrl       = CTRL_FROZEN;
          stateNxt   = MEM_WAIT;
          waitCntNxt = '0;
        end else begin
          ctrl = run_ctrl(exBranchTaken, luHaz);
        end
      end
      MEM_WAIT: begin
        // The frozen pipe keeps the access presented, so only memReady matters here.
        if (!memReady) begin
          ctrl = CTRL_FROZEN;
          if (waitCnt == WAIT_LAST) begin
            stateNxt = ERROR;
            errSet   = 1'b1;
          end else begin
            waitCntNxt = waitCnt + CNT_W'(1);
          end
        end else begin
          // Release cycle: any branch or hazard held during the wait is acted on now.
          ctrl       = run_ctrl(exBranchTaken, luHaz);
          stateNxt   = RUN;
          waitCntNxt = '0;
        end
      end
      ERROR: begin
        ctrl = CTRL_FROZEN;
      end
      default: begin
        stateNxt   = RUN;
        waitCntNxt = '0;
      end
    endcase
    // Hold every stage while reset is asserted, independent of the clock.
    if (reset) ctrl = CTRL_OFF;
  end

  assign pcWriteEn    = ctrl.pcWriteEn;
  assign ifidWriteEn  = ctrl.ifidWriteEn;
  assign idexWriteEn  = ctrl.idexWriteEn;
  assign exmemWriteEn = ctrl.exmemWriteEn;
  assign ifidFlush    = ctrl.ifidFlush;
  assign idexBubble   = ctrl.idexBubble;
  assign memwbBubble  = ctrl.memwbBubble;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= RUN;
      waitCnt       <= '0;
      memTimeoutErr <= 1'b0;
      stallCount    <= '0;
    end else begin
      state   <= stateNxt;
      waitCnt <= waitCntNxt;
      if (errSet) memTimeoutErr <= 1'b1;
      if (!ctrl.pcWriteEn && (stallCount != '1)) stallCount <= stallCount + STALL_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
module tb_pipe_stall_ctrl;

  localparam int TO = 15;

  logic       clock = 1'b0;
  logic       reset;
  logic [4:0] idRs, idRt, exWBAddress;
  logic       idUsesRt, exMemRead, exRegWriteEn, exBranchTaken, memReq, memReady;

  logic        pcWriteEn, ifidWriteEn, idexWriteEn, exmemWriteEn;
  logic        ifidFlush, idexBubble, memwbBubble, memTimeoutErr;
  logic [31:0] stallCount;

  logic        pcWriteEn4, ifidWriteEn4, idexWriteEn4, exmemWriteEn4;
  logic        ifidFlush4, idexBubble4, memwbBubble4, memTimeoutErr4;
  logic [3:0]  stallCount4;

  always #5 clock = ~clock;

  pipe_stall_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(4), .STALL_CNT_W(32)) dut (
    .clock(clock), .reset(reset), .idRs(idRs), .idRt(idRt), .idUsesRt(idUsesRt),
    .exMemRead(exMemRead), .exRegWriteEn(exRegWriteEn), .exWBAddress(exWBAddress),
    .exBranchTaken(exBranchTaken), .memReq(memReq), .memReady(memReady),
    .pcWriteEn(pcWriteEn), .ifidWriteEn(ifidWriteEn), .idexWriteEn(idexWriteEn),
    .exmemWriteEn(exmemWriteEn), .ifidFlush(ifidFlush), .idexBubble(idexBubble),
    .memwbBubble(memwbBubble), .memTimeoutErr(memTimeoutErr), .stallCount(stallCount)
  );

  pipe_stall_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(4), .STALL_CNT_W(4)) dut4 (
    .clock(clock), .reset(reset), .idRs(idRs), .idRt(idRt), .idUsesRt(idUsesRt),
    .exMemRead(exMemRead), .exRegWriteEn(exRegWriteEn), .exWBAddress(exWBAddress),
    .exBranchTaken(exBranchTaken), .memReq(memReq), .memReady(memReady),
    .pcWriteEn(pcWriteEn4), .ifidWriteEn(ifidWriteEn4), .idexWriteEn(idexWriteEn4),
    .exmemWriteEn(exmemWriteEn4), .ifidFlush(ifidFlush4), .idexBubble(idexBubble4),
    .memwbBubble(memwbBubble4), .memTimeoutErr(memTimeoutErr4), .stallCount(stallCount4)
  );

  wire [6:0] ctrl_o  = {pcWriteEn, ifidWriteEn, idexWriteEn, exmemWriteEn, ifidFlush, idexBubble, memwbBubble};
  wire [6:0] ctrl4_o = {pcWriteEn4, ifidWriteEn4, idexWriteEn4, exmemWriteEn4, ifidFlush4, idexBubble4, memwbBubble4};

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else n_pass++;
  endtask

  // Reference model: the pipe is either free or frozen; a frozen run that
  // lasts 1 + TO cycles latches the error for good. Stalls are a plain tally.
  bit     m_wait, m_err, m_frozen;
  int     m_run;
  longint m_stalls;

  task automatic model_clear();
    m_wait = 0; m_err = 0; m_run = 0; m_stalls = 0; m_frozen = 0;
  endtask

  task automatic model_ctrl(output logic [6:0] c);
    bit lu;
    if (reset) begin m_frozen = 0; c = 7'b0000000; return; end
    m_frozen = m_err || (m_wait ? !memReady : (memReq && !memReady));
    lu = exMemRead && exRegWriteEn && exWBAddress != 0 &&
         (exWBAddress == idRs || (idUsesRt && exWBAddress == idRt));
    if (m_frozen)           c = 7'b0000001;
    else if (exBranchTaken) c = 7'b1111110;
    else if (lu)            c = 7'b0011010;
    else                    c = 7'b1111000;
  endtask

  task automatic model_edge(input logic [6:0] c);
    if (reset) begin model_clear(); return; end
    if (!c[6]) m_stalls++;
    if (!m_err) begin
      if (m_frozen) begin
        m_run++;
        if (m_run == 1 + TO) begin m_err = 1; m_wait = 0; end
        else m_wait = 1;
      end else begin
        m_run = 0; m_wait = 0;
      end
    end
  endtask

  // One clock: check at the falling edge, advance the model on the rising edge.
  task automatic cycle(input string tag);
    logic [6:0] exp;
    longint sat4;
    @(negedge clock);
    if (reset) model_clear();
    model_ctrl(exp);
    sat4 = (m_stalls > 15) ? 15 : m_stalls;
    chk({tag, ":ctrl"},  ctrl_o, exp);
    chk({tag, ":ctrl4"}, ctrl4_o, exp);
    chk({tag, ":err"},   memTimeoutErr, m_err);
    chk({tag, ":cnt"},   stallCount, m_stalls);
    chk({tag, ":cnt4"},  stallCount4, sat4);
    @(posedge clock);
    model_edge(exp);
    #1;
  endtask

  task automatic idle_inputs();
    idRs = 0; idRt = 0; idUsesRt = 0; exMemRead = 0; exRegWriteEn = 0;
    exWBAddress = 0; exBranchTaken = 0; memReq = 0; memReady = 0;
  endtask

  logic [31:0] base;

  initial begin
    model_clear();
    idle_inputs();
    reset = 1'b1;
    #2;
    chk("rst_ctrl", ctrl_o, 7'b0);
    chk("rst_cnt", stallCount, 32'd0);
    chk("rst_err", memTimeoutErr, 1'b0);
    cycle("reset");
    reset = 1'b0;
    cycle("run_idle");

    // Load-use on rs: one stall cycle, then the hazard is gone.
    exMemRead = 1; exRegWriteEn = 1; exWBAddress = 5; idRs = 5;
    cycle("lu_rs");
    idle_inputs();
    cycle("lu_after");
    chk("lu_count", stallCount, 32'd1);
    // Same shape targeting r0: no stall.
    exMemRead = 1; exRegWriteEn = 1; exWBAddress = 0; idRs = 0;
    cycle("lu_r0");
    chk("lu_r0_count", stallCount, 32'd1);
    // rt dependency only counts when the instruction reads rt.
    exWBAddress = 7; idRs = 3; idRt = 7; idUsesRt = 0;
    cycle("lu_rt_unused");
    idUsesRt = 1;
    cycle("lu_rt_used");
    // Branch beats load-use.
    exWBAddress = 5; idRs = 5; exBranchTaken = 1;
    cycle("br_vs_lu");
    idle_inputs();

    // Memory wait: 3 frozen cycles, then release.
    base = stallCount;
    memReq = 1; memReady = 0;
    for (int i = 0; i < 3; i++) cycle("memwait");
    memReady = 1;
    cycle("mem_release");
    memReq = 0; memReady = 0;
    cycle("mem_after");
    chk("memwait_delta", stallCount - base, 32'd3);

    // Reset in the middle of a wait.
    memReq = 1; memReady = 0;
    cycle("pre_rst_wait1");
    cycle("pre_rst_wait2");
    reset = 1'b1;
    #2;
    chk("arst_ctrl", ctrl_o, 7'b0);
    chk("arst_cnt", stallCount, 32'd0);
    cycle("arst_hold");
    reset = 1'b0; memReq = 0;
    cycle("arst_release");
    chk("arst_err", memTimeoutErr, 1'b0);
    chk("arst_run", pcWriteEn, 1'b1);

    // Timeout: 16 frozen cycles latch the error; it sticks and counters saturate.
    memReq = 1; memReady = 0;
    for (int i = 0; i < 1 + TO; i++) cycle("timeout");
    chk("timeout_err", memTimeoutErr, 1'b1);
    memReady = 1;
    for (int i = 0; i < 20; i++) cycle("error_hold");
    chk("error_sticky", memTimeoutErr, 1'b1);
    chk("sat4", stallCount4, 4'hF);
    memReq = 0; memReady = 0;
    reset = 1'b1;
    cycle("error_reset");
    reset = 1'b0;

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      idRs          = 5'($urandom_range(0, 3));
      idRt          = 5'($urandom_range(0, 3));
      exWBAddress   = 5'($urandom_range(0, 3));
      idUsesRt      = 1'($urandom);
      exMemRead     = 1'($urandom);
      exRegWriteEn  = ($urandom_range(0, 3) != 0);
      exBranchTaken = ($urandom_range(0, 4) == 0);
      memReq        = m_wait ? 1'b1 : ($urandom_range(0, 3) == 0);
      memReady      = ($urandom_range(0, 3) == 0);
      reset         = ($urandom_range(0, 149) == 0);
      cycle("rand");
    end
    reset = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
